// File: rtl/switch_pkg.sv
// Shared switch definitions: reserved forwarding codes, broadcast MAC and the
// lookup-arbiter state encoding used by the learner and egress demux.
package switch_pkg;

    localparam logic [2:0]  PORT_FLOOD   = 3'b100;
    localparam logic [2:0]  PORT_DROP    = 3'b101;
    localparam logic [2:0]  PORT_INVALID = 3'b110;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } arb_state_t;

    // Apply broadcast and hairpin overrides to a learner answer.
    function automatic logic [2:0] resolve_port(
        input logic [47:0] dst_mac,
        input logic [2:0]  learned,
        input logic [2:0]  src_port
    );
        if (dst_mac == BCAST_MAC) begin
            return PORT_FLOOD;
        end
        if (learned == src_port) begin
            return PORT_DROP;
        end
        return learned;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping N-1 -> 0. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_scan;

    // Walk all N slots starting at the pointer; the first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_scan  = i_ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_any && i_req[w_scan]) begin
                o_any           = 1'b1;
                o_idx           = w_scan;
                o_grant[w_scan] = 1'b1;
            end
            w_scan = (w_scan == IDX_W'(N - 1)) ? '0 : w_scan + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Round-robin front end to the MAC-learning table: serialises ingress lookups
// onto the single learner interface and returns the forwarding port.
module mac_lookup_arbiter
    import switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_PORTS-1:0]    i_req_valid,
    input  logic [NUM_PORTS*48-1:0] i_req_dst_mac,
    input  logic [NUM_PORTS*48-1:0] i_req_src_mac,
    output logic [NUM_PORTS-1:0]    o_req_ready,
    output logic [NUM_PORTS-1:0]    o_resp_valid,
    output logic [2:0]              o_resp_port,
    output logic                    o_ml_en,
    output logic [47:0]             o_ml_src_mac,
    output logic [47:0]             o_ml_dst_mac,
    output logic [2:0]              o_ml_src_port,
    input  logic                    i_ml_done,
    input  logic                    i_ml_busy,
    input  logic [2:0]              i_ml_dst_port,
    output logic [CNT_W-1:0]        o_lookup_cnt,
    output logic [CNT_W-1:0]        o_timeout_cnt
);

    localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic [NUM_PORTS-1:0]   r_gnt_oh;
    logic [TMR_W-1:0]       r_timer;
    logic [NUM_PORTS-1:0]   r_req_ready;
    logic [NUM_PORTS-1:0]   r_resp_valid;
    logic [2:0]             r_resp_port;
    logic                   r_ml_en;
    logic [47:0]            r_ml_src_mac;
    logic [47:0]            r_ml_dst_mac;
    logic [2:0]             r_ml_src_port;
    logic [CNT_W-1:0]       r_lookup_cnt;
    logic [CNT_W-1:0]       r_timeout_cnt;

    logic [NUM_PORTS-1:0]   w_gnt_oh;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_gnt_any;
    logic [47:0]            w_sel_dst;
    logic [47:0]            w_sel_src;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    // One-hot mux of the granted port's MAC pair.
    always_comb begin
        w_sel_dst = '0;
        w_sel_src = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_dst = i_req_dst_mac[i*48 +: 48];
                w_sel_src = i_req_src_mac[i*48 +: 48];
            end
        end
    end

    // Lookup sequencer with registered outputs and saturating statistics.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_gnt_idx     <= '0;
            r_gnt_oh      <= '0;
            r_timer       <= '0;
            r_req_ready   <= '0;
            r_resp_valid  <= '0;
            r_resp_port   <= PORT_INVALID;
            r_ml_en       <= 1'b0;
            r_ml_src_mac  <= '0;
            r_ml_dst_mac  <= '0;
            r_ml_src_port <= '0;
            r_lookup_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            // Pulse outputs default low; the state that needs them re-asserts.
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_ml_en      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_any && !i_ml_busy) begin
                        r_gnt_oh      <= w_gnt_oh;
                        r_gnt_idx     <= w_gnt_idx;
                        r_ml_dst_mac  <= w_sel_dst;
                        r_ml_src_mac  <= w_sel_src;
                        r_ml_src_port <= 3'(w_gnt_idx);
                        r_req_ready   <= w_gnt_oh;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ml_en <= 1'b1;
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_timer <= r_timer + TMR_W'(1);
                    // A done on the final timer cycle still carries a real answer.
                    if (i_ml_done) begin
                        r_resp_port  <= resolve_port(r_ml_dst_mac, i_ml_dst_port, r_ml_src_port);
                        r_resp_valid <= r_gnt_oh;
                        r_state      <= RESP;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_resp_port  <= PORT_INVALID;
                        r_resp_valid <= r_gnt_oh;
                        if (r_timeout_cnt != '1) begin
                            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (r_lookup_cnt != '1) begin
                        r_lookup_cnt <= r_lookup_cnt + CNT_W'(1);
                    end
                    r_ptr   <= (r_gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                     : r_gnt_idx + IDX_W'(1);
                    r_state <= DRAIN;
                end
                DRAIN: begin
                    // Learner may still be writing the table; hold off new issues.
                    if (!i_ml_busy) begin
                        r_resp_port <= PORT_INVALID;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_port   = r_resp_port;
    assign o_ml_en       = r_ml_en;
    assign o_ml_src_mac  = r_ml_src_mac;
    assign o_ml_dst_mac  = r_ml_dst_mac;
    assign o_ml_src_port = r_ml_src_port;
    assign o_lookup_cnt  = r_lookup_cnt;
    assign o_timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Self-checking bench for mac_lookup_arbiter with an inline learner mock and a
// round-robin / override reference model.
module tb_mac_lookup_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*48-1:0] req_dst_flat;
    logic [N*48-1:0] req_src_flat;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [2:0]      resp_port;
    logic            ml_en;
    logic [47:0]     ml_src_mac;
    logic [47:0]     ml_dst_mac;
    logic [2:0]      ml_src_port;
    logic            ml_done;
    logic            ml_busy;
    logic [2:0]      ml_dst_port;
    logic [CNT_W-1:0] lookup_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    logic [47:0] dst_m [N];
    logic [47:0] src_m [N];

    int checks = 0;
    int errors = 0;
    int ptr_m = 0;
    int lookups_m = 0;
    int timeouts_m = 0;
    int grants_m = 0;
    int en_pulses = 0;
    int en_busy = 0;

    mac_lookup_arbiter #(
        .NUM_PORTS (N),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .i_req_dst_mac (req_dst_flat),
        .i_req_src_mac (req_src_flat),
        .o_req_ready   (req_ready),
        .o_resp_valid  (resp_valid),
        .o_resp_port   (resp_port),
        .o_ml_en       (ml_en),
        .o_ml_src_mac  (ml_src_mac),
        .o_ml_dst_mac  (ml_dst_mac),
        .o_ml_src_port (ml_src_port),
        .i_ml_done     (ml_done),
        .i_ml_busy     (ml_busy),
        .i_ml_dst_port (ml_dst_port),
        .o_lookup_cnt  (lookup_cnt),
        .o_timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_dst_flat = '0;
        req_src_flat = '0;
        for (int i = 0; i < N; i++) begin
            req_dst_flat[i*48 +: 48] = dst_m[i];
            req_src_flat[i*48 +: 48] = src_m[i];
        end
    end

    // Learner-side protocol monitor: count starts and starts issued while busy.
    always @(posedge clk) begin
        if (!rst) begin
            if (ml_en) en_pulses++;
            if (ml_en && ml_busy) en_busy++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "req_ready"},   64'(req_ready),   64'd0);
        chk({pfx, "resp_valid"},  64'(resp_valid),  64'd0);
        chk({pfx, "resp_port"},   64'(resp_port),   64'd6);
        chk({pfx, "ml_en"},       64'(ml_en),       64'd0);
        chk({pfx, "ml_src_mac"},  64'(ml_src_mac),  64'd0);
        chk({pfx, "ml_dst_mac"},  64'(ml_dst_mac),  64'd0);
        chk({pfx, "ml_src_port"}, 64'(ml_src_port), 64'd0);
        chk({pfx, "lookup_cnt"},  64'(lookup_cnt),  64'd0);
        chk({pfx, "timeout_cnt"}, 64'(timeout_cnt), 64'd0);
    endtask

    // Reference round-robin: first requester at/after the pointer, modulo N.
    function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
        for (int o = 0; o < N; o++) begin
            if (mask[2'((ptr + o) % N)]) return (ptr + o) % N;
        end
        return 0;
    endfunction

    function automatic logic [2:0] model_port(input logic [47:0] dst, input logic [2:0] lres,
                                              input int g, input bit timed_out);
        if (timed_out) return 3'b110;
        if (dst == 48'hFFFF_FFFF_FFFF) return 3'b100;
        if (int'(lres) == g) return 3'b101;
        return lres;
    endfunction

    task automatic rand_macs();
        logic [63:0] tmp;
        for (int i = 0; i < N; i++) begin
            tmp = {$urandom, $urandom};
            dst_m[i] = tmp[47:0];
            if ($urandom_range(0, 3) == 0) dst_m[i] = 48'hFFFF_FFFF_FFFF;
            tmp = {$urandom, $urandom};
            src_m[i] = tmp[47:0];
        end
    endtask

    // One full transaction for expected port g; learner answers lres in WAIT
    // cycle d (counting the ml_en cycle as 0) unless never is set.
    task automatic serve_one(input int g, input int d, input logic [2:0] lres,
                             input bit never, input bit clear_rest);
        int n;
        int k;
        bit got;
        logic [2:0] want;
        logic [47:0] gdst;
        n = 0;
        while (req_ready == '0 && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready", 64'(req_ready), 64'(1) << g);
        gdst = dst_m[g];
        want = model_port(gdst, lres, g, never);
        tick();
        req_valid[2'(g)] = 1'b0;
        grants_m++;
        chk("req_ready_pulse", 64'(req_ready), 64'd0);
        chk("ml_en", 64'(ml_en), 64'd1);
        chk("ml_src_port", 64'(ml_src_port), 64'(g));
        chk("ml_dst_mac", 64'(ml_dst_mac), 64'(gdst));
        chk("ml_src_mac", 64'(ml_src_mac), 64'(src_m[g]));
        k = 0;
        got = 1'b0;
        while (!got && k < TIMEOUT + 20) begin
            tick();
            k++;
            ml_busy = 1'b1;
            ml_done = (!never && k == d);
            ml_dst_port = (k == d) ? lres : 3'($urandom_range(0, 7));
            if (resp_valid != '0) got = 1'b1;
        end
        ml_done = 1'b0;
        chk("resp_latency", 64'(k), never ? 64'(TIMEOUT) : 64'(d + 1));
        chk("resp_valid", 64'(resp_valid), 64'(1) << g);
        chk("resp_port", 64'(resp_port), 64'(want));
        if (lookups_m < 65535) lookups_m++;
        if (never && timeouts_m < 65535) timeouts_m++;
        ptr_m = (g + 1) % N;
        tick();
        chk("resp_valid_pulse", 64'(resp_valid), 64'd0);
        chk("resp_port_drain", 64'(resp_port), 64'(want));
        chk("lookup_cnt", 64'(lookup_cnt), 64'(lookups_m));
        chk("timeout_cnt", 64'(timeout_cnt), 64'(timeouts_m));
        tick();
        ml_busy = 1'b0;
        if (clear_rest) req_valid = '0;
        tick();
        chk("resp_port_idle", 64'(resp_port), 64'd6);
    endtask

    initial begin
        logic [N-1:0] seen;
        int g;
        rst = 1'b1;
        req_valid = '0;
        ml_done = 1'b0;
        ml_busy = 1'b0;
        ml_dst_port = '0;
        for (int i = 0; i < N; i++) begin
            dst_m[i] = '0;
            src_m[i] = '0;
        end
        repeat (3) tick();
        chk_reset("reset_");
        rst = 1'b0;
        tick();

        // Single port 2 lookup, learner answers 3'b001 after 6 cycles.
        dst_m[2] = 48'h0011_2233_4455;
        src_m[2] = 48'h0A0B_0C0D_0E0F;
        req_valid = 4'b0100;
        serve_one(model_grant(req_valid, ptr_m), 6, 3'b001, 1'b0, 1'b1);

        // All four request together: order follows the rotating pointer.
        rand_macs();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin
            g = model_grant(req_valid, ptr_m);
            serve_one(g, 2 + i, 3'b111, 1'b0, 1'b0);
        end
        req_valid = 4'b0001;
        serve_one(model_grant(req_valid, ptr_m), 3, 3'b010, 1'b0, 1'b1);
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin
            g = model_grant(req_valid, ptr_m);
            serve_one(g, 1 + i, 3'b000, 1'b0, 1'b0);
        end

        // Broadcast overrides the learner.
        dst_m[1] = 48'hFFFF_FFFF_FFFF;
        req_valid = 4'b0010;
        serve_one(model_grant(req_valid, ptr_m), 4, 3'b011, 1'b0, 1'b1);

        // Hairpin: learner points back at the requester.
        dst_m[3] = 48'h0200_0000_0003;
        req_valid = 4'b1000;
        serve_one(model_grant(req_valid, ptr_m), 5, 3'b011, 1'b0, 1'b1);

        // Learner silent: timeout answer.
        dst_m[0] = 48'h0200_0000_0010;
        req_valid = 4'b0001;
        serve_one(model_grant(req_valid, ptr_m), 0, 3'b000, 1'b1, 1'b1);

        // Done on the very last timer cycle wins over the timeout.
        dst_m[1] = 48'h0200_0000_0011;
        req_valid = 4'b0010;
        serve_one(model_grant(req_valid, ptr_m), TIMEOUT - 1, 3'b010, 1'b0, 1'b1);

        // No grant while the learner is still busy.
        ml_busy = 1'b1;
        req_valid = 4'b0001;
        seen = '0;
        repeat (6) begin
            tick();
            seen |= req_ready;
        end
        chk("busy_blocks_grant", 64'(seen), 64'd0);
        ml_busy = 1'b0;
        serve_one(model_grant(req_valid, ptr_m), 2, 3'b001, 1'b0, 1'b1);

        // Randomised traffic.
        for (int it = 0; it < 24; it++) begin
            rand_macs();
            req_valid = 4'($urandom_range(1, 15));
            serve_one(model_grant(req_valid, ptr_m), $urandom_range(1, 20),
                      3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'b1);
        end

        // Reset while waiting on the learner.
        req_valid = 4'b0010;
        g = model_grant(req_valid, ptr_m);
        seen = '0;
        for (int n = 0; n < 50 && seen == '0; n++) begin
            tick();
            seen = req_ready;
        end
        chk("rst_pre_ready", 64'(req_ready), 64'(1) << g);
        tick();
        req_valid = '0;
        grants_m++;
        chk("rst_pre_ml_en", 64'(ml_en), 64'd1);
        tick();
        ml_busy = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ml_busy = 1'b0;
        chk_reset("midrst_");
        ptr_m = 0;
        lookups_m = 0;
        timeouts_m = 0;
        ml_done = 1'b1;
        ml_dst_port = 3'b001;
        seen = '0;
        repeat (5) begin
            seen |= resp_valid | req_ready | {N{ml_en}};
            tick();
            ml_done = 1'b0;
        end
        chk("midrst_no_resp", 64'(seen), 64'd0);
        dst_m[3] = 48'h0200_0000_0033;
        req_valid = 4'b1000;
        serve_one(model_grant(req_valid, ptr_m), 5, 3'b010, 1'b0, 1'b1);

        chk("ml_en_while_busy", 64'(en_busy), 64'd0);
        chk("ml_en_count", 64'(en_pulses), 64'(grants_m));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
